// File: rtl/des_req_arbiter.sv
// -----------------------------------------------------------------------------
// des_req_arbiter
//
// Shares a single iterative DES engine between two requesters. A round-robin
// pick chooses one pending request, its direction/key/block are latched, and
// the engine gets a one-cycle start. When the engine signals done, the result
// is registered onto the granted channel's o_Text and that channel gets a
// one-cycle done strobe. Requests arriving while a transaction is in flight
// are neither acknowledged nor queued; a level still high once the arbiter is
// back in IDLE counts as a fresh request.
//
// Optional feature (compile-time macro DES_ARB_TIMEOUT_EN):
//   Defined   - the engine wait is bounded by TIMEOUT cycles; on expiry the
//               transaction ends with o_fDone and o_fErr together and o_Text
//               keeps its previous value.
//   Undefined - the engine wait is unbounded and o_fErr0/o_fErr1 are 0.
//
// Parameters:
//   TIMEOUT      engine-wait limit in cycles (used only with the macro);
//                must be above the 18-cycle engine latency and fit the
//                6-bit wait counter.
//
// Ports:
//   i_Clk                clock, rising edge
//   i_Rst                synchronous reset, active low
//   i_Req0/1             request levels, held until the matching o_Ack
//   i_Dec0/1             direction per channel: 1 = decrypt, 0 = encrypt
//   i_Key0/1, i_Text0/1  64-bit key and input block per channel
//   o_Ack0/1             one-cycle pulse: request accepted, inputs latched
//   o_fDone0/1           one-cycle pulse: result valid on o_Text0/1
//   o_fErr0/1            one-cycle pulse alongside o_fDone: engine timeout
//   o_Text0/1            registered result, held until that channel's next
//                        completion
//   o_CoreStart          one-cycle engine start
//   o_CoreDec/Key/Text   engine operands, driven from the latched registers
//   i_CoreDone           engine done pulse (only honoured while waiting)
//   i_CoreText           engine result, valid while i_CoreDone = 1
// -----------------------------------------------------------------------------
module des_req_arbiter #(
    parameter int unsigned TIMEOUT = 40
) (
    input  logic        i_Clk,
    input  logic        i_Rst,

    input  logic        i_Req0,
    input  logic        i_Dec0,
    input  logic [63:0] i_Key0,
    input  logic [63:0] i_Text0,
    output logic        o_Ack0,
    output logic        o_fDone0,
    output logic        o_fErr0,
    output logic [63:0] o_Text0,

    input  logic        i_Req1,
    input  logic        i_Dec1,
    input  logic [63:0] i_Key1,
    input  logic [63:0] i_Text1,
    output logic        o_Ack1,
    output logic        o_fDone1,
    output logic        o_fErr1,
    output logic [63:0] o_Text1,

    output logic        o_CoreStart,
    output logic        o_CoreDec,
    output logic [63:0] o_CoreKey,
    output logic [63:0] o_CoreText,
    input  logic        i_CoreDone,
    input  logic [63:0] i_CoreText
);

    // The wait counter is 6 bits wide and the engine needs 18 cycles, so
    // anything outside (18, 64] cannot work.
    if (TIMEOUT <= 18 || TIMEOUT > 64) begin : g_bad_timeout
        $error("des_req_arbiter: TIMEOUT must be in 19..64");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        grant;
    logic        grant_nxt;
    logic        last;
    logic        last_nxt;

    logic        latch_en;
    logic        capture;

    logic        start_nxt;
    logic        ack0_nxt;
    logic        ack1_nxt;
    logic        done0_nxt;
    logic        done1_nxt;

    logic        dec_q;
    logic [63:0] key_q;
    logic [63:0] text_q;

`ifdef DES_ARB_TIMEOUT_EN
    localparam logic [5:0] WAIT_LAST = 6'(TIMEOUT - 1);

    logic [5:0]  wait_cnt;
    logic        timeout_hit;
    logic        err0_nxt;
    logic        err1_nxt;
    logic        err0_q;
    logic        err1_q;

    assign timeout_hit = (state == WAIT) && (wait_cnt == WAIT_LAST);
`endif

    // -------------------------------------------------------------------------
    // Next-state and next-output logic. Every strobe is computed one state
    // ahead and registered, so each pulse lines up with the state it belongs
    // to (Ack/Start during ISSUE, Done/Err during RESP).
    // -------------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        last_nxt  = last;
        latch_en  = 1'b0;
        capture   = 1'b0;
        start_nxt = 1'b0;
        ack0_nxt  = 1'b0;
        ack1_nxt  = 1'b0;
        done0_nxt = 1'b0;
        done1_nxt = 1'b0;
`ifdef DES_ARB_TIMEOUT_EN
        err0_nxt  = 1'b0;
        err1_nxt  = 1'b0;
`endif

        case (state)
            IDLE: begin
                if (i_Req0 || i_Req1) begin
                    // On a tie the channel that was not served last wins.
                    grant_nxt = (i_Req0 && i_Req1) ? ~last : i_Req1;
                    latch_en  = 1'b1;
                    start_nxt = 1'b1;
                    ack0_nxt  = ~grant_nxt;
                    ack1_nxt  = grant_nxt;
                    state_nxt = ISSUE;
                end
            end

            ISSUE: begin
                // A done pulse here cannot belong to this transaction.
                state_nxt = WAIT;
            end

            WAIT: begin
                // A done arriving on the limit cycle still counts as success.
                if (i_CoreDone) begin
                    capture   = 1'b1;
                    done0_nxt = ~grant;
                    done1_nxt = grant;
                    state_nxt = RESP;
                end
`ifdef DES_ARB_TIMEOUT_EN
                else if (timeout_hit) begin
                    done0_nxt = ~grant;
                    done1_nxt = grant;
                    err0_nxt  = ~grant;
                    err1_nxt  = grant;
                    state_nxt = RESP;
                end
`endif
            end

            RESP: begin
                last_nxt  = grant;
                state_nxt = IDLE;
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State, operand latches and registered outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge i_Clk) begin
        if (!i_Rst) begin
            state       <= IDLE;
            grant       <= 1'b0;
            last        <= 1'b1;
            dec_q       <= 1'b0;
            key_q       <= 64'd0;
            text_q      <= 64'd0;
            o_CoreStart <= 1'b0;
            o_Ack0      <= 1'b0;
            o_Ack1      <= 1'b0;
            o_fDone0    <= 1'b0;
            o_fDone1    <= 1'b0;
            o_Text0     <= 64'd0;
            o_Text1     <= 64'd0;
        end else begin
            state       <= state_nxt;
            grant       <= grant_nxt;
            last        <= last_nxt;
            o_CoreStart <= start_nxt;
            o_Ack0      <= ack0_nxt;
            o_Ack1      <= ack1_nxt;
            o_fDone0    <= done0_nxt;
            o_fDone1    <= done1_nxt;

            if (latch_en) begin
                dec_q  <= grant_nxt ? i_Dec1  : i_Dec0;
                key_q  <= grant_nxt ? i_Key1  : i_Key0;
                text_q <= grant_nxt ? i_Text1 : i_Text0;
            end

            // Only the granted channel's result register moves.
            if (capture && !grant) begin
                o_Text0 <= i_CoreText;
            end
            if (capture && grant) begin
                o_Text1 <= i_CoreText;
            end
        end
    end

`ifdef DES_ARB_TIMEOUT_EN
    // -------------------------------------------------------------------------
    // Engine-wait counter: zero on the first WAIT cycle, +1 per WAIT cycle.
    // -------------------------------------------------------------------------
    always_ff @(posedge i_Clk) begin
        if (!i_Rst) begin
            wait_cnt <= 6'd0;
            err0_q   <= 1'b0;
            err1_q   <= 1'b0;
        end else begin
            err0_q <= err0_nxt;
            err1_q <= err1_nxt;
            if (state == WAIT) begin
                wait_cnt <= wait_cnt + 6'd1;
            end else begin
                wait_cnt <= 6'd0;
            end
        end
    end

    assign o_fErr0 = err0_q;
    assign o_fErr1 = err1_q;
`else
    assign o_fErr0 = 1'b0;
    assign o_fErr1 = 1'b0;
`endif

    assign o_CoreDec  = dec_q;
    assign o_CoreKey  = key_q;
    assign o_CoreText = text_q;

endmodule

// File: tb/tb_des_req_arbiter.sv
// -----------------------------------------------------------------------------
// tb_des_req_arbiter
//
// Drives two requesters against des_req_arbiter and stands in for the DES
// engine with a fixed-latency behavioural core (18 cycles from start to done).
// The core knows the classic DES test vector in both directions and uses a
// simple keyed scramble for any other operands, which is all the arbiter needs
// to prove that the right operands went in and the right result came back.
//
// Expected behaviour is computed from the arbitration rules: winner =
// the lone requester, or !last on a tie; Ack/Start one cycle after the request
// is sampled, Done twenty cycles after it, loser outputs frozen throughout.
// -----------------------------------------------------------------------------
module tb_des_req_arbiter;

    localparam logic [63:0] KEY_V = 64'h133457799BBCDFF1;
    localparam logic [63:0] PT_V  = 64'h0123456789ABCDEF;
    localparam logic [63:0] CT_V  = 64'h85E813540F0AB405;

    logic        clk;
    logic        rst_n;
    logic        req0, req1, dec0, dec1;
    logic [63:0] key0, key1, text0, text1;
    logic        o_Ack0, o_Ack1, o_fDone0, o_fDone1, o_fErr0, o_fErr1;
    logic [63:0] o_Text0, o_Text1;
    logic        o_CoreStart, o_CoreDec;
    logic [63:0] o_CoreKey, o_CoreText;
    logic        core_done;
    logic [63:0] core_text;

    // Engine stand-in
    logic        eng_busy, eng_done, eng_hang, extra_done;
    logic [4:0]  eng_cnt;
    logic [63:0] eng_res;

    int n_checks = 0;
    int n_errors = 0;

    // Reference-model state
    logic        exp_last;
    logic [63:0] exp_text0, exp_text1;

    des_req_arbiter #(.TIMEOUT(40)) dut (
        .i_Clk       (clk),
        .i_Rst       (rst_n),
        .i_Req0      (req0),
        .i_Dec0      (dec0),
        .i_Key0      (key0),
        .i_Text0     (text0),
        .o_Ack0      (o_Ack0),
        .o_fDone0    (o_fDone0),
        .o_fErr0     (o_fErr0),
        .o_Text0     (o_Text0),
        .i_Req1      (req1),
        .i_Dec1      (dec1),
        .i_Key1      (key1),
        .i_Text1     (text1),
        .o_Ack1      (o_Ack1),
        .o_fDone1    (o_fDone1),
        .o_fErr1     (o_fErr1),
        .o_Text1     (o_Text1),
        .o_CoreStart (o_CoreStart),
        .o_CoreDec   (o_CoreDec),
        .o_CoreKey   (o_CoreKey),
        .o_CoreText  (o_CoreText),
        .i_CoreDone  (core_done),
        .i_CoreText  (core_text)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [63:0] eng_f(input logic [63:0] k, input logic [63:0] t,
                                          input logic d);
        if (k == KEY_V && t == PT_V && !d) return CT_V;
        if (k == KEY_V && t == CT_V && d)  return PT_V;
        if (d) return (t ^ {k[31:0], k[63:32]}) - 64'd1;
        return (t + 64'd1) ^ {k[31:0], k[63:32]};
    endfunction

    // Start seen at edge S+1 (start visible in the cycle after S) -> done
    // visible in the cycle after edge S+18, i.e. 18 cycles after start.
    always @(posedge clk) begin
        if (!rst_n) begin
            eng_busy <= 1'b0;
            eng_cnt  <= 5'd0;
            eng_done <= 1'b0;
            eng_res  <= 64'd0;
        end else begin
            eng_done <= 1'b0;
            if (o_CoreStart) begin
                eng_busy <= 1'b1;
                eng_cnt  <= 5'd17;
                eng_res  <= eng_f(o_CoreKey, o_CoreText, o_CoreDec);
            end else if (eng_busy) begin
                if (eng_cnt == 5'd1) begin
                    eng_busy <= 1'b0;
                    eng_done <= !eng_hang;
                end
                eng_cnt <= eng_cnt - 5'd1;
            end
        end
    end

    assign core_done = eng_done | extra_done;
    assign core_text = eng_done ? eng_res : 64'hBAD0_BAD0_BAD0_BAD0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        exp_last  = 1'b1;
        exp_text0 = 64'd0;
        exp_text1 = 64'd0;
    endtask

    task automatic new_data(input int ch);
        if (ch == 0) begin
            key0  = {$urandom, $urandom};
            text0 = {$urandom, $urandom};
            dec0  = 1'($urandom_range(1));
        end else begin
            key1  = {$urandom, $urandom};
            text1 = {$urandom, $urandom};
            dec1  = 1'($urandom_range(1));
        end
    endtask

    // One IDLE cycle between transactions: nothing may strobe.
    task automatic idle_cycle(input string tag);
        step();
        chk({tag, "_idle_ack"},  {62'd0, o_Ack1, o_Ack0}, 64'd0);
        chk({tag, "_idle_done"}, {62'd0, o_fDone1, o_fDone0}, 64'd0);
    endtask

    // Requests are already set up (raised at a negedge in IDLE). Follows one
    // transaction to completion and checks it against the rules.
    task automatic transact(input string tag, input bit inj_issue_done);
        int          win;
        int          done_n;
        logic [63:0] exp_res, w_key, w_text;
        logic        w_dec;
        logic        ack_w, ack_l, done_w, done_l, err_w, err_l;
        logic [63:0] text_w, text_l, exp_l;

        win     = (req0 && req1) ? (exp_last ? 0 : 1) : (req0 ? 0 : 1);
        w_key   = win ? key1  : key0;
        w_text  = win ? text1 : text0;
        w_dec   = win ? dec1  : dec0;
        exp_res = eng_f(w_key, w_text, w_dec);
        exp_l   = win ? exp_text0 : exp_text1;
        done_n  = 0;

        for (int n = 1; n <= 60 && done_n == 0; n++) begin
            step();
            ack_w  = win ? o_Ack1   : o_Ack0;
            ack_l  = win ? o_Ack0   : o_Ack1;
            done_w = win ? o_fDone1 : o_fDone0;
            done_l = win ? o_fDone0 : o_fDone1;
            err_w  = win ? o_fErr1  : o_fErr0;
            err_l  = win ? o_fErr0  : o_fErr1;
            text_w = win ? o_Text1  : o_Text0;
            text_l = win ? o_Text0  : o_Text1;

            chk({tag, "_ack_win"},   {63'd0, ack_w}, {63'd0, n == 1});
            chk({tag, "_ack_lose"},  {63'd0, ack_l}, 64'd0);
            chk({tag, "_start"},     {63'd0, o_CoreStart}, {63'd0, n == 1});
            chk({tag, "_done_lose"}, {62'd0, err_l, done_l}, 64'd0);
            chk({tag, "_text_lose"}, text_l, exp_l);

            if (n == 1) begin
                chk({tag, "_core_dec"},  {63'd0, o_CoreDec}, {63'd0, w_dec});
                chk({tag, "_core_key"},  o_CoreKey, w_key);
                chk({tag, "_core_text"}, o_CoreText, w_text);
                if (win == 1) req1 = 1'b0;
                else          req0 = 1'b0;
                if (inj_issue_done) extra_done = 1'b1;
            end else begin
                extra_done = 1'b0;
            end

            if (done_w) begin
                done_n = n;
                chk({tag, "_err_win"},  {63'd0, err_w}, 64'd0);
                chk({tag, "_text_win"}, text_w, exp_res);
            end
        end
        chk({tag, "_done_latency"}, 64'(done_n), 64'd20);

        exp_last = 1'(win);
        if (win == 1) exp_text1 = exp_res;
        else          exp_text0 = exp_res;
    endtask

    initial begin
        rst_n = 1'b0;
        req0 = 1'b0; req1 = 1'b0; dec0 = 1'b0; dec1 = 1'b0;
        key0 = 64'd0; key1 = 64'd0; text0 = 64'd0; text1 = 64'd0;
        eng_hang = 1'b0; extra_done = 1'b0;
        exp_last = 1'b1; exp_text0 = 64'd0; exp_text1 = 64'd0;

        // Reset state
        do_reset();
        chk("rst_ack",   {62'd0, o_Ack1, o_Ack0}, 64'd0);
        chk("rst_done",  {62'd0, o_fDone1, o_fDone0}, 64'd0);
        chk("rst_err",   {62'd0, o_fErr1, o_fErr0}, 64'd0);
        chk("rst_start", {63'd0, o_CoreStart}, 64'd0);
        chk("rst_text0", o_Text0, 64'd0);
        chk("rst_text1", o_Text1, 64'd0);
        chk("rst_ckey",  o_CoreKey, 64'd0);
        chk("rst_ctext", o_CoreText, 64'd0);
        chk("rst_cdec",  {63'd0, o_CoreDec}, 64'd0);

        // Known-answer encrypt on channel 0
        req0 = 1'b1; key0 = KEY_V; text0 = PT_V; dec0 = 1'b0;
        transact("kat_enc", 1'b0);
        chk("kat_enc_text0", o_Text0, CT_V);
        chk("kat_enc_text1", o_Text1, 64'd0);
        idle_cycle("kat_enc");

        // Simultaneous requests after reset, twice over
        do_reset();
        req0 = 1'b1; req1 = 1'b1; new_data(0); new_data(1);
        transact("tie_a", 1'b0);
        idle_cycle("tie_a");
        transact("tie_b", 1'b0);
        idle_cycle("tie_b");
        req0 = 1'b1; req1 = 1'b1; new_data(0); new_data(1);
        transact("tie_c", 1'b0);
        idle_cycle("tie_c");
        transact("tie_d", 1'b0);
        idle_cycle("tie_d");

        // Known-answer decrypt on channel 1
        req1 = 1'b1; key1 = KEY_V; text1 = CT_V; dec1 = 1'b1;
        transact("kat_dec", 1'b0);
        chk("kat_dec_text1", o_Text1, PT_V);
        idle_cycle("kat_dec");

        // Randomised request patterns
        for (int i = 0; i < 30; i++) begin
            if (!req0 && $urandom_range(1) == 1) begin req0 = 1'b1; new_data(0); end
            if (!req1 && $urandom_range(1) == 1) begin req1 = 1'b1; new_data(1); end
            if (!req0 && !req1) begin
                if ($urandom_range(1) == 1) begin req1 = 1'b1; new_data(1); end
                else                        begin req0 = 1'b1; new_data(0); end
            end
            transact("rnd", 1'b0);
            idle_cycle("rnd");
        end
        // Drain any request left pending by the random loop
        while (req0 || req1) begin
            transact("drain", 1'b0);
            idle_cycle("drain");
        end

        // Stray engine done in IDLE, then in ISSUE
        extra_done = 1'b1;
        step();
        extra_done = 1'b0;
        for (int n = 0; n < 4; n++) begin
            step();
            chk("stray_idle_done",  {62'd0, o_fDone1, o_fDone0}, 64'd0);
            chk("stray_idle_start", {63'd0, o_CoreStart}, 64'd0);
        end
        req0 = 1'b1; new_data(0);
        transact("stray_issue", 1'b1);
        idle_cycle("stray_issue");

        // Reset while waiting for the engine
        req0 = 1'b1; new_data(0);
        step();
        chk("rstwait_ack0", {63'd0, o_Ack0}, 64'd1);
        req0 = 1'b0;
        for (int n = 0; n < 5; n++) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        exp_last = 1'b1; exp_text0 = 64'd0; exp_text1 = 64'd0;
        for (int n = 0; n < 30; n++) begin
            step();
            chk("rstwait_done", {62'd0, o_fDone1, o_fDone0}, 64'd0);
        end
        chk("rstwait_text0", o_Text0, 64'd0);
        req0 = 1'b1; req1 = 1'b1; new_data(0); new_data(1);
        transact("rstwait_tie", 1'b0);
        idle_cycle("rstwait_tie");
        transact("rstwait_tie2", 1'b0);
        idle_cycle("rstwait_tie2");

        // Engine never finishes
        eng_hang = 1'b1;
        req0 = 1'b1; new_data(0);
`ifdef DES_ARB_TIMEOUT_EN
        begin
            int done_n;
            done_n = 0;
            for (int n = 1; n <= 60 && done_n == 0; n++) begin
                step();
                if (n == 1) req0 = 1'b0;
                chk("tmo_lose", {62'd0, o_fErr1, o_fDone1}, 64'd0);
                if (o_fDone0) begin
                    done_n = n;
                    chk("tmo_err0",  {63'd0, o_fErr0}, 64'd1);
                    chk("tmo_text0", o_Text0, exp_text0);
                end else begin
                    chk("tmo_err0_early", {63'd0, o_fErr0}, 64'd0);
                end
            end
            chk("tmo_latency", 64'(done_n), 64'd42);
            exp_last = 1'b0;
            idle_cycle("tmo");
        end
`else
        for (int n = 1; n <= 200; n++) begin
            step();
            if (n == 1) req0 = 1'b0;
            chk("hang_done", {62'd0, o_fDone1, o_fDone0}, 64'd0);
            chk("hang_err",  {62'd0, o_fErr1, o_fErr0}, 64'd0);
        end
        do_reset();
`endif
        eng_hang = 1'b0;

        // Arbiter must be usable again afterwards
        req0 = 1'b1; req1 = 1'b1; new_data(0); new_data(1);
        transact("after", 1'b0);
        idle_cycle("after");
        transact("after2", 1'b0);
        idle_cycle("after2");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
